// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter sitting beside the data RAM.
//
// Stores to TXDATA queue bytes into a small TX FIFO; a serializer drains the
// FIFO onto an 8N1 line, LSB first. Loads return q/hit_q one cycle later, the
// same latency as the RAM, so write-back can mux between the two.
//
// Register window (8 bytes at BASE_ADDR, address[1:0] ignored):
//   +0 TXDATA  write: push data[7:0]      read: 0
//   +4 STATUS  read : bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky),
//                     bit4 parity enabled, bits[15:8] FIFO count
//              write: data[3]=1 clears overflow
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit.
//
// Ports:
//   clk      core clock
//   reset_n  asynchronous active-low reset
//   address  byte address from the memory stage
//   data     store data
//   wren     store strobe
//   rden     load strobe
//   q        registered load data
//   hit_q    registered: previous-cycle load hit this window
//   tx       serial line, idle high

module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          CLK_DIV    = 434,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic        rden,
   output logic [31:0] q,
   output logic        hit_q,
   output logic        tx
);

   // state  | meaning
   // IDLE   | line high, waiting for a byte in the FIFO
   // START  | start bit (low) for CLK_DIV cycles
   // DATA   | 8 data bits, LSB first, CLK_DIV cycles each
   // PARITY | even parity bit (only with UART_TX_PARITY_EN)
   // STOP   | stop bit (high); on its last cycle chain straight into the next byte

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] BIT_RELOAD = TW'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

   state_t        state;
   logic [TW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic hit, sel_status, wr_txdata, wr_status;
   logic full, empty, busy, push, pop;
   logic [7:0]  head;
   logic [31:0] status;
   logic        unused_bits;

   assign hit        = address[31:3] == BASE_ADDR[31:3];
   assign sel_status = address[2];
   assign wr_txdata  = wren & hit & ~sel_status;
   assign wr_status  = wren & hit & sel_status;

   assign full  = count == CW'(FIFO_DEPTH);
   assign empty = count == '0;
   assign busy  = state != ST_IDLE;
   assign head  = fifo_mem[rd_ptr];

   // full/empty come from registered count, so a push into a full FIFO is
   // dropped even if the serializer pops on the same edge
   assign push = wr_txdata & ~full;
   assign pop  = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & (bit_cnt == '0)));

   assign unused_bits = &{1'b0, address[1:0], data[31:8]};

   always_comb begin
      status       = '0;
      status[0]    = full;
      status[1]    = empty;
      status[2]    = busy;
      status[3]    = overflow;
      status[15:8] = 8'(count);
`ifdef UART_TX_PARITY_EN
      status[4]    = 1'b1;
`endif
   end

   // FIFO storage needs no reset; pointers and count define its contents
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= data[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (wr_txdata & full)          overflow <= 1'b1;
         else if (wr_status & data[3])  overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q     <= '0;
         hit_q <= 1'b0;
      end else begin
         hit_q <= rden & hit;
         q     <= (rden & hit & sel_status) ? status : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state   <= ST_START;
                  bit_cnt <= BIT_RELOAD;
                  shift   <= head;
                  tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^head;
`endif
               end
            end
            ST_START: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - TW'(1);
               end else begin
                  state   <= ST_DATA;
                  bit_cnt <= BIT_RELOAD;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
               end
            end
            ST_DATA: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - TW'(1);
               end else if (bit_idx == 3'd7) begin
                  bit_cnt <= BIT_RELOAD;
`ifdef UART_TX_PARITY_EN
                  state   <= ST_PARITY;
                  tx      <= par_bit;
`else
                  state   <= ST_STOP;
                  tx      <= 1'b1;
`endif
               end else begin
                  bit_cnt <= BIT_RELOAD;
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - TW'(1);
               end else begin
                  state   <= ST_STOP;
                  bit_cnt <= BIT_RELOAD;
                  tx      <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - TW'(1);
               end else if (pop) begin
                  // back-to-back frame: no idle gap between stop and start
                  state   <= ST_START;
                  bit_cnt <= BIT_RELOAD;
                  shift   <= head;
                  tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^head;
`endif
               end else begin
                  state   <= ST_IDLE;
                  tx      <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

   localparam int          DIV  = 4;
   localparam logic [31:0] BASE = 32'hFFFF_0000;

`ifdef UART_TX_PARITY_EN
   localparam bit          PAR_EN = 1'b1;
   localparam logic [31:0] PAR_V  = 32'h10;
`else
   localparam bit          PAR_EN = 1'b0;
   localparam logic [31:0] PAR_V  = 32'h0;
`endif

   localparam int FRAME_CYC = (PAR_EN ? 11 : 10) * DIV;
   localparam logic [31:0] ST_EMPTY = 32'h2 | PAR_V;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] address;
   logic [31:0] data;
   logic        wren;
   logic        rden;
   logic [31:0] q;
   logic        hit_q;
   logic        tx;

   int checks   = 0;
   int failures = 0;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .data(data),
      .wren(wren), .rden(rden), .q(q), .hit_q(hit_q), .tx(tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_q;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      wren = 1'b0; rden = 1'b0; address = '0; data = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // one bus cycle: inputs held across a single edge, outputs sampled 1ns later
   task automatic access(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] q_s, output logic h_s);
      wren = w; rden = r; address = a; data = d;
      @(posedge clk);
      #1;
      wren = 1'b0; rden = 1'b0;
      q_s = q; h_s = hit_q;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int slot;
      slot = (k - 1) / DIV;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (PAR_EN && slot == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic exp_tx(input logic [7:0] b0, input logic [7:0] b1, input int nfr, input int k);
      if (k <= FRAME_CYC) return frame_bit(b0, k);
      if (nfr > 1 && k <= 2 * FRAME_CYC) return frame_bit(b1, k - FRAME_CYC);
      return 1'b1;
   endfunction

   // k counts edges after the first store's edge; the next edge is k=kstart
   task automatic check_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input int nfr, input int kstart, input int kend);
      for (int k = kstart; k <= kend; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_tx_k%0d", tag, k), {31'b0, tx}, {31'b0, exp_tx(b0, b1, nfr, k)});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] qs;
      logic        hs;
      int          lows;

      vecs[0]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0,         ST_EMPTY, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'h0,    1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0,         32'h0,    1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_0007, 32'h0,         ST_EMPTY, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_0008, 32'h0,         32'h0,    1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'hFFFE_0004, 32'h0,         32'h0,    1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_0004, 32'hFFFF_FFF7, 32'h0,    1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0,         ST_EMPTY, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_0004, 32'h8,         ST_EMPTY, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h33,        32'h0,    1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0,         ST_EMPTY, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 32'hFFFF_0006, 32'h0,         ST_EMPTY, 1'b1};

      do_reset();
      chk("reset_tx", {31'b0, tx}, 32'h1);
      chk("reset_q", q, 32'h0);
      chk("reset_hit_q", {31'b0, hit_q}, 32'h0);

      for (int i = 0; i < 12; i++) begin
         access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, qs, hs);
         chk($sformatf("vec%0d_q", i), qs, vecs[i].exp_q);
         chk($sformatf("vec%0d_hit", i), {31'b0, hs}, {31'b0, vecs[i].exp_hit});
      end

      // single frame 0x55, then busy must clear exactly FRAME_CYC+1 edges after the store
      access(1'b1, 1'b0, BASE, 32'h55, qs, hs);
      check_tx("f55", 8'h55, 8'h00, 1, 1, FRAME_CYC);
      access(1'b0, 1'b1, BASE + 32'h4, 32'h0, qs, hs);
      chk("f55_busy_last", qs, 32'h6 | PAR_V);
      access(1'b0, 1'b1, BASE + 32'h4, 32'h0, qs, hs);
      chk("f55_busy_clear", qs, ST_EMPTY);
      chk("f55_idle_tx", {31'b0, tx}, 32'h1);

      // back-to-back frames, no idle gap
      access(1'b1, 1'b0, BASE, 32'h41, qs, hs);
      access(1'b1, 1'b0, BASE, 32'h42, qs, hs);
      check_tx("f4142", 8'h41, 8'h42, 2, 2, 2 * FRAME_CYC + 1);

`ifdef UART_TX_PARITY_EN
      access(1'b1, 1'b0, BASE, 32'h07, qs, hs);
      check_tx("fpar07", 8'h07, 8'h00, 1, 1, FRAME_CYC + 1);
`endif

      // overflow: six consecutive stores, sixth dropped
      do_reset();
      for (int i = 0; i < 6; i++) access(1'b1, 1'b0, BASE, 32'hA0 + 32'(i), qs, hs);
      access(1'b0, 1'b1, BASE + 32'h4, 32'h0, qs, hs);
      chk("ovf_status", qs, 32'h40D | PAR_V);
      access(1'b1, 1'b1, BASE + 32'h4, 32'h8, qs, hs);
      chk("ovf_clear_prewrite", qs, 32'h40D | PAR_V);
      access(1'b0, 1'b1, BASE + 32'h4, 32'h0, qs, hs);
      chk("ovf_cleared", qs, 32'h405 | PAR_V);

      // async reset during data bit 3 of a 0x00 frame
      do_reset();
      access(1'b1, 1'b0, BASE, 32'h00, qs, hs);
      repeat (18) @(posedge clk);
      #1;
      chk("mid_bit3_tx", {31'b0, tx}, 32'h0);
      #3 reset_n = 1'b0;
      #1;
      chk("mid_reset_tx", {31'b0, tx}, 32'h1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      lows = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1) lows++;
      end
      chk("post_reset_low_cycles", 32'(lows), 32'h0);
      access(1'b0, 1'b1, BASE + 32'h4, 32'h0, qs, hs);
      chk("post_reset_status", qs, ST_EMPTY);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
